prog_unit: RTL and testbench

- Top-level, self-contained "program engine" that runs three fixed data-processing programs in sequence over a shared 256x8 data memory.
- Each `req` pulse starts the next program in the order P1, P2, P3, then wraps back to P1.
- P1 is a Hamming(16,11) SECDED encoder.
- P2 is a single-error-correcting decoder.
- P3 counts a 5-bit pattern across a 32-byte string.
- Completion is signalled on `ack`; results are written back into the same memory.

---
 rtl/prog_pkg.sv | 76 +++++++
 rtl/data_mem.sv | 26 ++
 rtl/prog_unit.sv | 184 ++++++++++++++++++
 tb/tb_prog_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// ============================================================================
// prog_pkg : shared types, address map and Hamming(16,11) helpers for prog_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P1_RUN = 3'd1,
    ST_P2_RUN = 3'd2,
    ST_P3_RUN = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PROG_P1 = 2'd0,
    PROG_P2 = 2'd1,
    PROG_P3 = 2'd2
  } prog_t;

  localparam logic [7:0] P1_IN  = 8'd0;
  localparam logic [7:0] P1_OUT = 8'd30;
  localparam logic [7:0] P2_IN  = 8'd64;
  localparam logic [7:0] P2_OUT = 8'd94;
  localparam logic [7:0] STR    = 8'd128;
  localparam logic [7:0] PAT    = 8'd160;
  localparam logic [7:0] RES    = 8'd192;

  function automatic prog_t next_prog(input prog_t p);
    case (p)
      PROG_P1: next_prog = PROG_P2;
      PROG_P2: next_prog = PROG_P3;
      default: next_prog = PROG_P1;
    endcase
  endfunction

  // d11[0] is d1; the code word bit index equals the Hamming position.
  function automatic logic [15:0] hamming_encode(input logic [10:0] d11);
    logic [11:1] d;
    logic [15:0] w;
    d       = d11;
    w[15:9] = d[11:5];
    w[8]    = ^d[11:5];
    w[7:5]  = d[4:2];
    w[4]    = ^{d[11:8], d[4:2]};
    w[3]    = d[1];
    w[2]    = ^{d[11:10], d[7:6], d[4:3], d[1]};
    w[1]    = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
    w[0]    = ^w[15:1];
    return w;
  endfunction

  function automatic logic [3:0] hamming_syndrome(input logic [15:0] w16);
    logic [3:0] s;
    s = 4'd0;
    for (int j = 1; j < 16; j++) begin
      if (w16[j]) s = s ^ 4'(j);
    end
    return s;
  endfunction

  // Single-error correction followed by data extraction, d[0] = d1.
  function automatic logic [10:0] hamming_decode(input logic [15:0] w16);
    logic [3:0]  s;
    logic [15:0] w;
    s = hamming_syndrome(w16);
    w = w16;
    if (s != 4'd0) w[s] = ~w[s];
    return {w[15:9], w[7:5], w[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem.sv
// ============================================================================
// data_mem : 256x8 data memory, combinational read, synchronous write
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (we_i) core[waddr_i] <= wdata_i;
  end

  assign rdata_o = core[raddr_i];

endmodule

`default_nettype wire

// File: rtl/prog_unit.sv
// ============================================================================
// prog_unit : sequences P1 (SECDED encode), P2 (SEC decode), P3 (pattern count)
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_unit
  import prog_pkg::*;
#(
  parameter int NUM_MSG   = 15,
  parameter int STR_BYTES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ack
);

  state_t     state_q;
  prog_t      prog_q;
  logic       ack_q;
  logic [6:0] idx_q;
  logic [1:0] phase_q;
  logic [7:0] lo_q, hi_q, prev_q;
  logic [7:0] ctb_q, cto_q, cts_q;
  logic [4:0] pat_q;

  logic        wr_en;
  logic [7:0]  rd_addr, rd_data, wr_addr, wr_data;
  logic [15:0] enc;
  logic [10:0] dec;
  logic [15:0] pair;
  logic [2:0]  in_cnt, cross_cnt;

  data_mem dm1 (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign ack  = ack_q;
  assign enc  = hamming_encode({rd_data[2:0], lo_q});
  assign dec  = hamming_decode({rd_data, lo_q});
  assign pair = {prev_q, rd_data};

  // In-byte windows start at bits 0..3; windows straddling into the previous byte start at 4..7.
  always_comb begin
    in_cnt    = 3'd0;
    cross_cnt = 3'd0;
    for (int t = 0; t < 4; t++) begin
      if (rd_data[t +: 5] == pat_q) in_cnt = in_cnt + 3'd1;
    end
    for (int t = 4; t < 8; t++) begin
      if (idx_q != 7'd0 && pair[t +: 5] == pat_q) cross_cnt = cross_cnt + 3'd1;
    end
  end

  always_comb begin
    rd_addr = 8'd0;
    wr_en   = 1'b0;
    wr_addr = 8'd0;
    wr_data = 8'd0;
    case (state_q)
      ST_P1_RUN, ST_P2_RUN: begin
        case (phase_q)
          2'd0: rd_addr = ((state_q == ST_P1_RUN) ? P1_IN : P2_IN) + {idx_q, 1'b0};
          2'd1: begin
            rd_addr = ((state_q == ST_P1_RUN) ? P1_IN : P2_IN) + {idx_q, 1'b1};
            wr_en   = 1'b1;
            wr_addr = ((state_q == ST_P1_RUN) ? P1_OUT : P2_OUT) + {idx_q, 1'b0};
            wr_data = (state_q == ST_P1_RUN) ? enc[7:0] : dec[7:0];
          end
          2'd2: begin
            wr_en   = 1'b1;
            wr_addr = ((state_q == ST_P1_RUN) ? P1_OUT : P2_OUT) + {idx_q, 1'b1};
            wr_data = hi_q;
          end
          default: ;
        endcase
      end
      ST_P3_RUN: begin
        case (phase_q)
          2'd0: rd_addr = PAT;
          2'd1: rd_addr = STR + {1'b0, idx_q};
          2'd2: begin
            wr_en   = 1'b1;
            wr_addr = RES + {1'b0, idx_q};
            wr_data = (idx_q == 7'd0) ? ctb_q : (idx_q == 7'd1) ? cto_q : cts_q;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      prog_q  <= PROG_P1;
      ack_q   <= 1'b0;
      idx_q   <= 7'd0;
      phase_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            ack_q   <= 1'b0;
            idx_q   <= 7'd0;
            phase_q <= 2'd0;
            case (prog_q)
              PROG_P1: state_q <= ST_P1_RUN;
              PROG_P2: state_q <= ST_P2_RUN;
              default: state_q <= ST_P3_RUN;
            endcase
          end
        end
        ST_P1_RUN, ST_P2_RUN: begin
          case (phase_q)
            2'd0: begin
              lo_q    <= rd_data;
              phase_q <= 2'd1;
            end
            2'd1: begin
              hi_q    <= (state_q == ST_P1_RUN) ? enc[15:8] : {5'd0, dec[10:8]};
              phase_q <= 2'd2;
            end
            default: begin
              if (idx_q == 7'(NUM_MSG - 1)) begin
                state_q <= ST_DONE;
                ack_q   <= 1'b1;
                prog_q  <= next_prog(prog_q);
              end else begin
                idx_q   <= idx_q + 7'd1;
                phase_q <= 2'd0;
              end
            end
          endcase
        end
        ST_P3_RUN: begin
          case (phase_q)
            2'd0: begin
              pat_q   <= rd_data[4:0];
              ctb_q   <= 8'd0;
              cto_q   <= 8'd0;
              cts_q   <= 8'd0;
              idx_q   <= 7'd0;
              phase_q <= 2'd1;
            end
            2'd1: begin
              ctb_q  <= ctb_q + {5'd0, in_cnt};
              cto_q  <= cto_q + {7'd0, |in_cnt};
              cts_q  <= cts_q + {5'd0, in_cnt} + {5'd0, cross_cnt};
              prev_q <= rd_data;
              if (idx_q == 7'(STR_BYTES - 1)) begin
                idx_q   <= 7'd0;
                phase_q <= 2'd2;
              end else begin
                idx_q <= idx_q + 7'd1;
              end
            end
            default: begin
              if (idx_q == 7'd2) begin
                state_q <= ST_DONE;
                ack_q   <= 1'b1;
                prog_q  <= next_prog(prog_q);
              end else begin
                idx_q <= idx_q + 7'd1;
              end
            end
          endcase
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_unit.sv
// ============================================================================
// tb_prog_unit : randomized self-checking bench with a shadow-memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req = 1'b0;
  logic ack;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sh [256];

  always #5 clk = ~clk;

  prog_unit #(.NUM_MSG(15), .STR_BYTES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ack   (ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    sh[a] = v;
    dut.dm1.core[a] = v;
  endtask

  function automatic bit is_pow2(input int p);
    return (p == 1 || p == 2 || p == 4 || p == 8);
  endfunction

  // Data bits fill non-power-of-two positions in ascending order; parity k covers positions with bit k set.
  function automatic logic [15:0] m_encode(input logic [10:0] d);
    logic [15:0] w;
    int n;
    w = 16'd0;
    n = 0;
    for (int p = 1; p < 16; p++) begin
      if (!is_pow2(p)) begin
        w[p] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if (((p >> k) & 1) == 1 && !is_pow2(p)) par = par ^ w[p];
      end
      w[1 << k] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] m_decode(input logic [15:0] win);
    logic [15:0] w;
    logic [10:0] d;
    int s, n;
    w = win;
    s = 0;
    for (int j = 1; j < 16; j++) if (w[j]) s = s ^ j;
    if (s != 0) w[s] = ~w[s];
    n = 0;
    for (int p = 1; p < 16; p++) begin
      if (!is_pow2(p)) begin
        d[n] = w[p];
        n++;
      end
    end
    return d;
  endfunction

  task automatic model_p1();
    for (int i = 0; i < 15; i++) begin
      logic [15:0] w;
      w = m_encode({sh[2*i+1][2:0], sh[2*i]});
      sh[30+2*i] = w[7:0];
      sh[31+2*i] = w[15:8];
    end
  endtask

  task automatic model_p2();
    for (int i = 0; i < 15; i++) begin
      logic [10:0] d;
      d = m_decode({sh[65+2*i], sh[64+2*i]});
      sh[94+2*i] = d[7:0];
      sh[95+2*i] = {5'd0, d[10:8]};
    end
  endtask

  task automatic model_p3();
    logic [255:0] s;
    int pat, ctb, cto, cts;
    pat = int'(sh[160][4:0]);
    ctb = 0;
    cto = 0;
    cts = 0;
    for (int j = 0; j < 32; j++) begin
      int hits;
      hits = 0;
      s[255-8*j -: 8] = sh[128+j];
      for (int k = 0; k < 4; k++) if (((int'(sh[128+j]) >> k) & 31) == pat) hits++;
      ctb += hits;
      if (hits > 0) cto++;
    end
    for (int m = 0; m < 252; m++) if (int'(s[251-m +: 5]) == pat) cts++;
    sh[192] = 8'(ctb);
    sh[193] = 8'(cto);
    sh[194] = 8'(cts);
  endtask

  task automatic preload_random();
    for (int a = 0; a < 256; a++) poke(a, 8'($urandom));
    for (int i = 0; i < 15; i++) begin
      logic [15:0] w;
      int e;
      w = m_encode(11'($urandom));
      e = int'($urandom_range(0, 16));
      if (e < 16) w[e] = ~w[e];
      poke(64 + 2*i, w[7:0]);
      poke(65 + 2*i, w[15:8]);
    end
  endtask

  task automatic cmp_mem(input string tag);
    for (int a = 0; a < 256; a++)
      check_val($sformatf("%s_mem[%0d]", tag, a), {24'd0, dut.dm1.core[a]}, {24'd0, sh[a]});
  endtask

  task automatic run_prog(input string tag);
    int n;
    req = 1'b1;
    tick();
    req = 1'b0;
    check_val({tag, "_ack_clear"}, {31'd0, ack}, 32'd0);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    check_val({tag, "_busy_ack"}, {31'd0, ack}, 32'd0);
    n = 0;
    while (ack !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check_val({tag, "_done"}, {31'd0, ack}, 32'd1);
    tick();
    tick();
    check_val({tag, "_ack_hold"}, {31'd0, ack}, 32'd1);
  endtask

  task automatic run_p3_random(input string tag);
    logic [4:0] pat;
    pat = 5'($urandom);
    poke(160, {3'($urandom), pat});
    for (int j = 0; j < 32; j++) begin
      if ($urandom_range(0, 1) == 0) poke(128 + j, 8'({3'($urandom), pat} << $urandom_range(0, 3)));
      else poke(128 + j, 8'($urandom));
    end
    run_prog(tag);
    model_p3();
    cmp_mem(tag);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    check_val("rst_ack", {31'd0, ack}, 32'd0);
    reset = 1'b1;
    tick();

    preload_random();
    poke(0, 8'h00); poke(1, {5'($urandom), 3'b000});
    poke(2, 8'hFF); poke(3, {5'($urandom), 3'b111});
    poke(4, 8'h01); poke(5, {5'($urandom), 3'b000});
    poke(64, 8'hDF); poke(65, 8'hFF);
    poke(66, 8'hFE); poke(67, 8'hFF);
    poke(68, 8'h0F); poke(69, 8'h00);

    run_prog("p1a");
    model_p1();
    cmp_mem("p1a");
    check_val("p1_m0", {16'd0, dut.dm1.core[31], dut.dm1.core[30]}, 32'h0000);
    check_val("p1_m1", {16'd0, dut.dm1.core[33], dut.dm1.core[32]}, 32'hFFFF);
    check_val("p1_m2", {16'd0, dut.dm1.core[35], dut.dm1.core[34]}, 32'h000F);

    run_prog("p2a");
    model_p2();
    cmp_mem("p2a");
    check_val("p2_bit5", {16'd0, dut.dm1.core[95], dut.dm1.core[94]}, 32'h07FF);
    check_val("p2_bit0", {16'd0, dut.dm1.core[97], dut.dm1.core[96]}, 32'h07FF);
    check_val("p2_clean", {16'd0, dut.dm1.core[99], dut.dm1.core[98]}, 32'h0001);

    poke(160, 8'hA0);
    for (int j = 0; j < 32; j++) poke(128 + j, 8'h00);
    run_prog("p3a");
    model_p3();
    cmp_mem("p3a");
    check_val("p3_zero", {8'd0, dut.dm1.core[192], dut.dm1.core[193], dut.dm1.core[194]},
              {8'd0, 8'd128, 8'd32, 8'd252});

    preload_random();
    run_prog("p1wrap");
    model_p1();
    cmp_mem("p1wrap");
    run_prog("p2b");
    model_p2();
    cmp_mem("p2b");
    poke(160, 8'h15);
    for (int j = 0; j < 32; j++) poke(128 + j, 8'h55);
    run_prog("p3b");
    model_p3();
    cmp_mem("p3b");
    check_val("p3_55", {8'd0, dut.dm1.core[192], dut.dm1.core[193], dut.dm1.core[194]},
              {8'd0, 8'd64, 8'd32, 8'd126});

    for (int r = 0; r < 3; r++) begin
      preload_random();
      run_prog($sformatf("p1r%0d", r));
      model_p1();
      cmp_mem($sformatf("p1r%0d", r));
      run_prog($sformatf("p2r%0d", r));
      model_p2();
      cmp_mem($sformatf("p2r%0d", r));
      run_p3_random($sformatf("p3r%0d", r));
    end

    preload_random();
    run_prog("p1pre");
    model_p1();
    cmp_mem("p1pre");
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    tick();
    check_val("midrst_ack", {31'd0, ack}, 32'd0);
    reset = 1'b1;
    tick();
    preload_random();
    run_prog("p1post");
    model_p1();
    cmp_mem("p1post");

    reset = 1'b0;
    tick();
    check_val("rst_clr_ack", {31'd0, ack}, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
